// File: rtl/dmem_ctrl.sv
// Data RAM and memory-mapped I/O controller for the CPU load/store path.
// Performs RISC-V lane selection and extension, and owns the LED register and switch synchronizer.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] SW_ADDR     = 32'hFFFF_0000,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  // state | meaning
  // IDLE  | ready for a request; rsp_valid pulses here right after RESP
  // RD    | RAM read in flight, lane extraction on the next edge
  // RESP  | response data and error registered, pulse issued on exit
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic [1:0]  ld_lane;
  logic [2:0]  ld_f3;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic          accept;
  logic [31:0]   addr_off;
  logic          in_ram;
  logic          is_sw;
  logic          is_led;
  logic          illegal;
  logic          misalign;
  logic          dec_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   mmio_word;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Unsigned wraparound turns the two-sided range check into one compare.
  assign addr_off = req_addr - RAM_BASE;
  assign in_ram   = addr_off < RAM_BYTES;
  assign word_idx = addr_off[AW+1:2];
  assign is_sw    = req_addr[31:2] == SW_ADDR[31:2];
  assign is_led   = req_addr[31:2] == LED_ADDR[31:2];

  assign illegal  = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                    (req_we && req_funct3[2]);
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign dec_err  = illegal || misalign || !(in_ram || is_sw || is_led) ||
                    (req_we && is_sw);

  assign mmio_word = is_sw ? {16'h0000, sw_sync} : {16'h0000, led};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h000000, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0000, h};
      default: extract = word;
    endcase
  endfunction

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && !dec_err && in_ram) begin
      if (req_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end else begin
        ram_q <= mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      led       <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      sw_meta   <= 16'h0000;
      sw_sync   <= 16'h0000;
      ld_lane   <= 2'b00;
      ld_f3     <= 3'b000;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else if (in_ram && !req_we) begin
              ld_lane <= req_addr[1:0];
              ld_f3   <= req_funct3;
              state   <= RD;
            end else if (req_we) begin
              if (is_led) begin
                if (be[0]) led[7:0]  <= wdata_rep[7:0];
                if (be[1]) led[15:8] <= wdata_rep[15:8];
              end
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              rsp_err   <= 1'b0;
              rsp_rdata <= extract(mmio_word, req_addr[1:0], req_funct3);
              state     <= RESP;
            end
          end
        end
        RD: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= extract(ram_q, ld_lane, ld_f3);
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-addressed reference model, queued expectations,
// independent response monitor checking data, error flag and latency.
module tb_dmem_ctrl;

  localparam longint RB    = 64'h8000_0000;
  localparam longint RSIZE = 64'd4096;
  localparam longint SWA   = 64'hFFFF_0000;
  localparam longint LEDA  = 64'hFFFF_0004;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] sw = 16'h0000;
  logic [15:0] led;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          op_id = 0;
  logic [7:0]  ram_b [longint];
  logic [15:0] led_m = 16'h0000;
  logic [15:0] sw_m = 16'h0000;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: memory is a byte map, loads assemble little-endian bytes and extend arithmetically.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err,
                              output int lat);
    longint a, v;
    int size, off;
    bit is_ram, is_swr, is_ledr, illegal, misal;
    logic [31:0] w;
    logic [7:0] bv;
    a = longint'(addr);
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    illegal = (size == 0) || (we && f3[2]);
    misal   = (size != 0) && ((a % size) != 0);
    is_ram  = (a >= RB) && (a < RB + RSIZE);
    is_swr  = (a / 4) == (SWA / 4);
    is_ledr = (a / 4) == (LEDA / 4);
    err = illegal || misal || !(is_ram || is_swr || is_ledr) || (we && is_swr);
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < size; k++) begin
          bv = wd[8*k +: 8];
          if (is_ram) ram_b[a - RB + k] = bv;
          else begin
            off = int'(a - LEDA) + k;
            if (off < 2) led_m[8*off +: 8] = bv;
          end
        end
      end else begin
        v = 0;
        w = is_swr ? {16'h0, sw_m} : {16'h0, led_m};
        for (int k = 0; k < size; k++) begin
          if (is_ram) bv = ram_b[a - RB + k];
          else bv = w[8*(int'(a % 4) + k) +: 8];
          v = v | (longint'(bv) << (8 * k));
        end
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
        rd  = v[31:0];
        lat = is_ram ? 2 : 1;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track, input bit keep, output int acc);
    logic [31:0] rd;
    logic err;
    int lat, t;
    bit got;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    got = 0; t = 0; acc = -1;
    while (!got && t < 20) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        got = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    chk($sformatf("accepted op%0d", op_id), 32'(got), 32'd1);
    if (got) begin
      acc = cyc;
      if (track) begin
        model_access(we, f3, addr, wd, rd, err, lat);
        sb.push_back('{rdata: rd, err: err, acc: acc, lat: lat, id: op_id});
      end
    end
    op_id++;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd);
    int acc;
    issue(we, f3, addr, wd, 1'b1, 1'b0, acc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid with nothing pending, rdata %h err %b",
                 rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rdata op%0d", e.id), rsp_rdata, e.rdata);
        chk($sformatf("err op%0d", e.id), 32'(rsp_err), 32'(e.err));
        chk($sformatf("latency op%0d", e.id), 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, t;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{F_B, F_H, F_W, F_BU, F_HU};

    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset led", 32'(led), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", 32'(req_ready), 32'd1);

    // Full word and extensions
    op(1, F_W, 32'h8000_0000, 32'd123);
    op(0, F_W, 32'h8000_0000, 32'h0);
    op(1, F_W, 32'h8000_0004, 32'hFFFF_FF80);
    op(0, F_B,  32'h8000_0004, 32'h0);
    op(0, F_BU, 32'h8000_0004, 32'h0);
    op(0, F_H,  32'h8000_0004, 32'h0);
    op(0, F_HU, 32'h8000_0006, 32'h0);
    op(1, F_B,  32'h8000_0005, 32'h0000_0012);
    op(0, F_W,  32'h8000_0004, 32'h0);
    // Errors and boundaries
    op(0, F_W, 32'h8000_0002, 32'h0);
    op(1, F_H, 32'h8000_0001, 32'h0000_BEEF);
    op(0, F_W, 32'h8000_0000, 32'h0);
    op(0, F_W, 32'h0000_0000, 32'h0);
    op(0, 3'b011, 32'h8000_0000, 32'h0);
    op(1, F_BU, 32'h8000_0000, 32'h0);
    op(1, F_W, 32'h8000_0FFC, 32'hCAFE_F00D);
    op(0, F_HU, 32'h8000_0FFE, 32'h0);
    op(0, F_W, 32'h8000_1000, 32'h0);
    // MMIO
    op(1, F_W, 32'hFFFF_0004, 32'hABCD_1234);
    chk("led after SW", 32'(led), 32'(led_m));
    op(1, F_B, 32'hFFFF_0004, 32'h0000_0055);
    chk("led after SB", 32'(led), 32'(led_m));
    op(1, F_H, 32'hFFFF_0006, 32'h0000_7777);
    chk("led after SH hi", 32'(led), 32'(led_m));
    op(0, F_HU, 32'hFFFF_0006, 32'h0);
    op(0, F_B, 32'hFFFF_0005, 32'h0);
    sw = 16'hA5A5; sw_m = 16'hA5A5;
    repeat (3) @(negedge clk);
    op(0, F_W, 32'hFFFF_0000, 32'h0);
    op(0, F_H, 32'hFFFF_0000, 32'h0);
    op(1, F_W, 32'hFFFF_0000, 32'h1);

    // Continuous valid: three loads, then two stores
    issue(0, F_W, 32'h8000_0000, 32'h0, 1'b1, 1'b1, a0);
    issue(0, F_B, 32'h8000_0005, 32'h0, 1'b1, 1'b1, a1);
    issue(0, F_HU, 32'h8000_0004, 32'h0, 1'b1, 1'b0, a2);
    chk("load spacing 1", 32'(a1 - a0), 32'd3);
    chk("load spacing 2", 32'(a2 - a1), 32'd3);
    issue(1, F_H, 32'hFFFF_0004, 32'h0000_9A9A, 1'b1, 1'b1, a0);
    issue(1, F_B, 32'hFFFF_0005, 32'h0000_0033, 1'b1, 1'b0, a1);
    chk("store spacing", 32'(a1 - a0), 32'd2);

    // Reset while a RAM load is in RD
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    issue(0, F_W, 32'h8000_0000, 32'h0, 1'b0, 1'b0, a0);
    @(negedge clk);
    rst = 1'b1;
    led_m = 16'h0000;
    #1;
    chk("led in reset", 32'(led), 32'(led_m));
    repeat (2) @(negedge clk);
    chk("rsp_valid in reset", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after mid reset", 32'(req_ready), 32'd1);
    op(0, F_W, 32'h8000_0004, 32'h0);
    repeat (3) @(negedge clk);

    // Random traffic over a prefilled RAM window and MMIO
    for (int i = 0; i < 16; i++) op(1, F_W, 32'h8000_0000 + 32'(4 * i), $urandom);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        6:       addr = 32'hFFFF_0004 + 32'($urandom_range(0, 3));
        7:       addr = 32'hFFFF_0000 + 32'($urandom_range(0, 3));
        8:       addr = 32'h8000_1000 + 32'($urandom_range(0, 7));
        9:       addr = 32'h0000_0100 + 32'($urandom_range(0, 3));
        default: addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      op(logic'($urandom_range(0, 2) == 0), f3, addr, $urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    chk("led after random", 32'(led), 32'(led_m));

    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
